// File: rtl/conv1_window_gen.sv
// rtl/conv1_window_gen.sv - 3x3x3 sliding-window generator feeding conv1 from a raster pixel stream
// Two line buffers hold rows y-2 and y-1; a 3x3 register window shifts left on every accepted pixel.

module conv1_window_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int STRIDE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_valid,
  input  logic         pix_sof,
  input  logic [47:0]  pix_data,
  output logic         win_valid,
  output logic [431:0] win_data,
  output logic         frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  localparam logic [0:0] S_PRIME = 1'b0;
  localparam logic [0:0] S_EMIT  = 1'b1;

  logic [XW-1:0]  x_q, x_d, x_eff;
  logic [YW-1:0]  y_q, y_d, y_eff;
  logic [0:0]     state_q, state_d, state_eff;
  logic [47:0]    lb0_q [IMG_W];
  logic [47:0]    lb1_q [IMG_W];
  logic [47:0]    win_q [3][3];
  logic [47:0]    win_d [3][3];
  logic [431:0]   win_data_q, win_data_d;
  logic           win_valid_q, frame_done_q;
  logic           emit, fdone, row_end, frame_end, stride_ok;

  always_comb begin
    // A start-of-frame marker forces the pixel to (0,0) and drops any partial frame.
    x_eff     = pix_sof ? '0 : x_q;
    y_eff     = pix_sof ? '0 : y_q;
    state_eff = pix_sof ? S_PRIME : state_q;
    row_end   = (x_eff == X_LAST);
    frame_end = row_end && (y_eff == Y_LAST);
    stride_ok = (STRIDE == 1) || (!x_eff[0] && !y_eff[0]);

    x_d        = x_q;
    y_d        = y_q;
    state_d    = state_q;
    win_data_d = win_data_q;
    emit       = 1'b0;
    fdone      = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end

    if (pix_valid) begin
      x_d = row_end ? '0 : x_eff + XW'(1);
      y_d = row_end ? ((y_eff == Y_LAST) ? '0 : y_eff + YW'(1)) : y_eff;

      state_d = state_eff;
      if (state_eff == S_PRIME && row_end && y_eff == YW'(1)) begin
        state_d = S_EMIT;
      end else if (state_eff == S_EMIT && frame_end) begin
        state_d = S_PRIME;
      end

      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_q[x_eff];
      win_d[1][2] = lb1_q[x_eff];
      win_d[2][2] = pix_data;

      emit  = (state_eff == S_EMIT) && (x_eff >= XW'(2)) && stride_ok;
      fdone = frame_end;

      if (emit) begin
        for (int n = 0; n < 3; n++) begin
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              win_data_d[144*n + 16*(3*r + c) +: 16] = win_d[r][c][16*n +: 16];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      state_q      <= S_PRIME;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      state_q      <= state_d;
      win_valid_q  <= emit;
      frame_done_q <= fdone;
      win_data_q   <= win_data_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // Line buffers are never reset: the two PRIME rows rewrite every entry before EMIT reads them.
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      lb0_q[x_eff] <= lb1_q[x_eff];
      lb1_q[x_eff] <= pix_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv1_window_gen.sv
// tb/tb_conv1_window_gen.sv - self-checking bench for conv1_window_gen
// Three configurations (4x4/1, 5x5/2, 16x16/1) checked every cycle against a frame-image model.

module tb_conv1_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         pv [3];
  logic         ps [3];
  logic [47:0]  pd [3];
  logic         wv [3];
  logic [431:0] wd [3];
  logic         fd [3];

  conv1_window_gen #(.IMG_W(4), .IMG_H(4), .STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_sof(ps[0]), .pix_data(pd[0]),
    .win_valid(wv[0]), .win_data(wd[0]), .frame_done(fd[0]));
  conv1_window_gen #(.IMG_W(5), .IMG_H(5), .STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_sof(ps[1]), .pix_data(pd[1]),
    .win_valid(wv[1]), .win_data(wd[1]), .frame_done(fd[1]));
  conv1_window_gen #(.IMG_W(16), .IMG_H(16), .STRIDE(1)) u2 (
    .clk(clk), .rst(rst), .pix_valid(pv[2]), .pix_sof(ps[2]), .pix_data(pd[2]),
    .win_valid(wv[2]), .win_data(wd[2]), .frame_done(fd[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [431:0] act, input logic [431:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int mw [3] = '{4, 5, 16};
  int mh [3] = '{4, 5, 16};
  int ms [3] = '{1, 2, 1};

  logic [47:0]  img [3][16][16];
  int           mx [3], my [3], last_idx [3];
  logic         exp_v [3], exp_f [3];
  logic [431:0] exp_d [3];

  int           wlog  [3][$];
  logic [431:0] wdlog [3][$];
  int           fdlog [3][$];
  logic         fdwv  [3][$];
  logic [431:0] ref_win [$];

  function automatic logic [431:0] window_of(int i, int y, int x);
    logic [431:0] w = '0;
    for (int n = 0; n < 3; n++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[144*n + 16*(3*r + c) +: 16] = img[i][y-2+r][x-2+c][16*n +: 16];
    return w;
  endfunction

  // Model: remember the whole frame image, derive each window straight from its coordinates.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mx[i] = 0; my[i] = 0;
        exp_v[i] = 1'b0; exp_f[i] = 1'b0; exp_d[i] = '0;
      end else if (pv[i]) begin
        if (ps[i]) begin
          mx[i] = 0; my[i] = 0;
        end
        img[i][my[i]][mx[i]] = pd[i];
        last_idx[i] = my[i] * mw[i] + mx[i];
        exp_v[i] = (my[i] >= 2) && (mx[i] >= 2) &&
                   ((mx[i] - 2) % ms[i] == 0) && ((my[i] - 2) % ms[i] == 0);
        if (exp_v[i]) exp_d[i] = window_of(i, my[i], mx[i]);
        exp_f[i] = (mx[i] == mw[i] - 1) && (my[i] == mh[i] - 1);
        mx[i]++;
        if (mx[i] == mw[i]) begin
          mx[i] = 0;
          my[i]++;
          if (my[i] == mh[i]) my[i] = 0;
        end
      end else begin
        exp_v[i] = 1'b0;
        exp_f[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("win_valid[%0d]", i), 432'(wv[i]), 432'(exp_v[i]));
      chk($sformatf("frame_done[%0d]", i), 432'(fd[i]), 432'(exp_f[i]));
      chk($sformatf("win_data[%0d]", i), wd[i], exp_d[i]);
      if (wv[i]) begin
        wlog[i].push_back(last_idx[i]);
        wdlog[i].push_back(wd[i]);
      end
      if (fd[i]) begin
        fdlog[i].push_back(wlog[i].size());
        fdwv[i].push_back(wv[i]);
      end
    end
  end

  function automatic logic [47:0] mk(int k);
    return {16'(k + 200), 16'(k + 100), 16'(k)};
  endfunction

  task automatic px(input int i, input logic [47:0] d, input logic sof);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      pv[j] = 1'b0; ps[j] = 1'b0;
    end
    pv[i] = 1'b1; pd[i] = d; ps[i] = sof;
  endtask

  // Idle cycles carry junk data and stray sof flags that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        pv[j] = 1'b0;
        ps[j] = 1'($urandom_range(0, 1));
        pd[j] = {16'($urandom), 32'($urandom)};
      end
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      wlog[i].delete(); wdlog[i].delete(); fdlog[i].delete(); fdwv[i].delete();
    end
  endtask

  task automatic cmp_windows(input string nm);
    int e_idx [4] = '{10, 11, 14, 15};
    chk({nm, "_count"}, 432'(wlog[0].size()), 432'(4));
    for (int k = 0; k < wlog[0].size() && k < 4; k++) begin
      chk({nm, "_idx"}, 432'(wlog[0][k]), 432'(e_idx[k]));
      chk({nm, "_data"}, wdlog[0][k], ref_win[k]);
    end
    chk({nm, "_fd_count"}, 432'(fdlog[0].size()), 432'(1));
  endtask

  initial begin
    int t0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int e5 [4] = '{12, 14, 22, 24};
    logic [431:0] w;
    logic [47:0]  rnd;

    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      pv[j] = 1'b0; ps[j] = 1'b0; pd[j] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_win_valid", 432'(wv[i]), '0);
      chk("reset_frame_done", 432'(fd[i]), '0);
      chk("reset_win_data", wd[i], '0);
    end
    rst = 1'b0;
    idle(2);

    // 4x4 continuous frame with hand-known windows
    clear_logs();
    for (int k = 0; k < 16; k++) px(0, mk(k), k == 0);
    idle(3);
    chk("t1_count", 432'(wlog[0].size()), 432'(4));
    for (int k = 0; k < wlog[0].size() && k < 4; k++)
      chk("t1_idx", 432'(wlog[0][k]), 432'((k < 2) ? 10 + k : 12 + k));
    w = (wdlog[0].size() > 0) ? wdlog[0][0] : '0;
    for (int k = 0; k < 9; k++) chk("t1_ch0_tap", 432'(w[16*k +: 16]), 432'(t0[k]));
    chk("t1_ch1_tap0", 432'(w[144 +: 16]), 432'(100));
    chk("t1_ch2_tap8", 432'(w[288 + 128 +: 16]), 432'(210));
    chk("t1_fd_count", 432'(fdlog[0].size()), 432'(1));
    if (fdlog[0].size() > 0) begin
      chk("t1_fd_after_last_window", 432'(fdlog[0][0]), 432'(4));
      chk("t1_fd_with_win_valid", 432'(fdwv[0][0]), 432'(1));
    end
    ref_win = wdlog[0];

    // Same stream with random gaps
    clear_logs();
    for (int k = 0; k < 16; k++) begin
      idle($urandom_range(0, 5));
      px(0, mk(k), k == 0);
    end
    idle(3);
    cmp_windows("t2_gaps");

    // Mid-frame sof abandons the partial frame
    clear_logs();
    for (int k = 0; k < 7; k++) px(0, mk(k), k == 0);
    for (int k = 0; k < 16; k++) px(0, mk(k), k == 0);
    idle(3);
    cmp_windows("t3_sof_abort");

    // Reset mid-frame, with a pixel presented during reset that must be dropped
    clear_logs();
    for (int k = 0; k < 10; k++) px(0, mk(k), k == 0);
    @(negedge clk);
    rst = 1'b1; pv[0] = 1'b1; pd[0] = mk(10); ps[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0; pv[0] = 1'b0;
    chk("t4_post_rst_win_valid", 432'(wv[0]), '0);
    chk("t4_post_rst_win_data", wd[0], '0);
    for (int k = 0; k < 16; k++) px(0, mk(k), 1'b0);
    idle(3);
    cmp_windows("t4_rst_restart");

    // 5x5 stride 2
    clear_logs();
    for (int k = 0; k < 25; k++) px(1, mk(k), k == 0);
    idle(3);
    chk("t5_count", 432'(wlog[1].size()), 432'(4));
    for (int k = 0; k < wlog[1].size() && k < 4; k++)
      chk("t5_idx", 432'(wlog[1][k]), 432'(e5[k]));
    chk("t5_fd_count", 432'(fdlog[1].size()), 432'(1));

    // Two back-to-back random 16x16 frames; first without sof
    clear_logs();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 256; k++) begin
        rnd = {16'($urandom), 32'($urandom)};
        px(2, rnd, (f == 1) && (k == 0));
      end
    end
    idle(3);
    chk("t6_count", 432'(wlog[2].size()), 432'(392));
    chk("t6_fd_count", 432'(fdlog[2].size()), 432'(2));
    if (fdlog[2].size() == 2) begin
      chk("t6_frame1_windows", 432'(fdlog[2][0]), 432'(196));
      chk("t6_frame2_windows", 432'(fdlog[2][1]), 432'(392));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
